// File: rtl/vfr_packet_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : vfr_packet_reader_if
//  Purpose  : Bundles the register slave bus, the memory read master bus and
//             the Avalon-ST output of the packet reader.
//             "slave" is the packet reader's view; "master" is the view of
//             the surrounding system (controller, memory, stream sink).
//  Revision : 1.0 - initial release
// ============================================================================
interface vfr_packet_reader_if #(
   parameter int ADDR_WIDTH = 32
);
   // register slave bus
   logic [2:0]            slave_address;
   logic                  slave_write;
   logic [31:0]           slave_writedata;
   logic                  slave_read;
   logic [31:0]           slave_readdata;
   logic                  slave_irq;
   // memory read master bus
   logic [ADDR_WIDTH-1:0] master_address;
   logic                  master_read;
   logic                  master_waitrequest;
   logic [31:0]           master_readdata;
   logic                  master_readdatavalid;
   // output stream
   logic [31:0]           dout_data;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  dout_startofpacket;
   logic                  dout_endofpacket;

   modport slave (
      input  slave_address, slave_write, slave_writedata, slave_read,
      output slave_readdata, slave_irq,
      output master_address, master_read,
      input  master_waitrequest, master_readdata, master_readdatavalid,
      output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
      input  dout_ready
   );

   modport master (
      output slave_address, slave_write, slave_writedata, slave_read,
      input  slave_readdata, slave_irq,
      input  master_address, master_read,
      output master_waitrequest, master_readdata, master_readdatavalid,
      input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
      output dout_ready
   );
endinterface
`default_nettype wire

// File: rtl/vfr_packet_reader.sv
`default_nettype none
// ============================================================================
//  Module   : vfr_packet_reader
//  Purpose  : Register bank plus memory read engine. On go it fetches one
//             packet of 32-bit words and emits a header word (packet type)
//             followed by the data words as an Avalon-ST packet, raising an
//             interrupt once the end-of-packet word is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module vfr_packet_reader #(
   parameter int FIFO_DEPTH  = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int WORDS_WIDTH = 32
) (
   input  wire logic          clock,
   input  wire logic          reset,
   vfr_packet_reader_if.slave bus
);
   localparam int         c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int         c_CNT_W = c_PTR_W + 1;
   localparam int         c_SUM_W = c_CNT_W + 1;
   localparam logic [2:0] c_REG_CONTROL   = 3'd0;
   localparam logic [2:0] c_REG_STATUS    = 3'd1;
   localparam logic [2:0] c_REG_INTERRUPT = 3'd2;
   localparam logic [2:0] c_REG_ADDRESS   = 3'd3;
   localparam logic [2:0] c_REG_TYPE      = 3'd4;
   localparam logic [2:0] c_REG_SAMPLES   = 3'd5;
   localparam logic [2:0] c_REG_WORDS     = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_READING, S_DRAIN} state_t;

   state_t                 r_state, w_state_next;
   // programmed registers
   logic                   r_irq_enable, r_irq_flag;
   logic [ADDR_WIDTH-1:0]  r_address;
   logic [3:0]             r_type;
   logic [WORDS_WIDTH-1:0] r_samples, r_words;
   logic [31:0]            r_readdata;
   // working copies for the packet in flight
   logic [ADDR_WIDTH-1:0]  r_cur_addr;
   logic [3:0]             r_type_work;
   logic [WORDS_WIDTH-1:0] r_words_work, r_remaining, r_received;
   logic [c_CNT_W-1:0]     r_outstanding;
   // output FIFO, entry = {sop, eop, data}
   logic [33:0]            r_fifo_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [c_CNT_W-1:0]     r_fifo_count;

   logic                   w_go, w_wr_ctrl, w_wr_int, w_running;
   logic                   w_fifo_empty, w_pop, w_eop_pop, w_rd_accept, w_last_word;
   logic                   w_credit, w_master_read, w_issue, w_hdr_push, w_push;
   logic [33:0]            w_head, w_push_entry;

   assign w_running    = (r_state != S_IDLE);
   assign w_wr_ctrl    = bus.slave_write && (bus.slave_address == c_REG_CONTROL);
   assign w_wr_int     = bus.slave_write && (bus.slave_address == c_REG_INTERRUPT);
   assign w_go         = w_wr_ctrl && bus.slave_writedata[0];
   assign w_fifo_empty = (r_fifo_count == '0);
   assign w_head       = r_fifo_mem[r_rd_ptr];
   assign w_pop        = !w_fifo_empty && bus.dout_ready;
   assign w_eop_pop    = w_pop && w_head[32];
   // late responses (e.g. after a reset) find no outstanding credit and are dropped
   assign w_rd_accept  = bus.master_readdatavalid && (r_outstanding != '0) &&
                         ((r_state == S_READING) || (r_state == S_DRAIN));
   assign w_last_word  = ((r_received + WORDS_WIDTH'(1)) == r_words_work);
   // every issued read owns a FIFO slot, so responses can never overflow it
   assign w_credit     = ({1'b0, r_fifo_count} + {1'b0, r_outstanding}) < c_SUM_W'(FIFO_DEPTH);
   assign w_push       = w_hdr_push || w_rd_accept;
   assign w_push_entry = w_hdr_push ? {1'b1, (r_words_work == '0), 28'd0, r_type_work}
                                    : {1'b0, w_last_word, bus.master_readdata};

   // state register
   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // next-state and read-request decode
   always_comb begin
      w_state_next  = r_state;
      w_master_read = 1'b0;
      w_issue       = 1'b0;
      w_hdr_push    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_go) w_state_next = S_HEADER;
         end
         S_HEADER: begin
            w_hdr_push   = 1'b1;
            w_state_next = (r_words_work == '0) ? S_DRAIN : S_READING;
         end
         S_READING: begin
            w_master_read = w_credit && (r_remaining != '0);
            w_issue       = w_master_read && !bus.master_waitrequest;
            if (w_issue && (r_remaining == WORDS_WIDTH'(1))) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if ((r_outstanding == '0) && w_eop_pop) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // FIFO storage; contents are qualified by the count, so no reset needed
   always_ff @(posedge clock) begin
      if (w_push) r_fifo_mem[r_wr_ptr] <= w_push_entry;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_fifo_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
            2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
            default: r_fifo_count <= r_fifo_count;
         endcase
      end
   end

   // working copies latched at go, read engine counters
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cur_addr    <= '0;
         r_type_work   <= '0;
         r_words_work  <= '0;
         r_remaining   <= '0;
         r_received    <= '0;
         r_outstanding <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_go) begin
            r_cur_addr   <= r_address;
            r_type_work  <= r_type;
            r_words_work <= r_words;
            r_remaining  <= r_words;
            r_received   <= '0;
         end else if (w_issue) begin
            r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(4);
            r_remaining <= r_remaining - WORDS_WIDTH'(1);
         end
         if (w_rd_accept) r_received <= r_received + WORDS_WIDTH'(1);
         case ({w_issue, w_rd_accept})
            2'b10:   r_outstanding <= r_outstanding + c_CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - c_CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // register bank writes, interrupt flag and registered readback
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_irq_enable <= 1'b0;
         r_irq_flag   <= 1'b0;
         r_address    <= '0;
         r_type       <= '0;
         r_samples    <= '0;
         r_words      <= '0;
         r_readdata   <= '0;
      end else begin
         if (w_wr_ctrl) r_irq_enable <= bus.slave_writedata[1];
         if (bus.slave_write) begin
            case (bus.slave_address)
               c_REG_ADDRESS: r_address <= ADDR_WIDTH'(bus.slave_writedata);
               c_REG_TYPE:    r_type    <= bus.slave_writedata[3:0];
               c_REG_SAMPLES: r_samples <= WORDS_WIDTH'(bus.slave_writedata);
               c_REG_WORDS:   r_words   <= WORDS_WIDTH'(bus.slave_writedata);
               default: ;
            endcase
         end
         // set has priority over a simultaneous clear
         if (w_eop_pop)                             r_irq_flag <= 1'b1;
         else if (w_wr_int && bus.slave_writedata[1]) r_irq_flag <= 1'b0;
         if (bus.slave_read) begin
            case (bus.slave_address)
               c_REG_CONTROL:   r_readdata <= {30'd0, r_irq_enable, 1'b0};
               c_REG_STATUS:    r_readdata <= {31'd0, w_running};
               c_REG_INTERRUPT: r_readdata <= {30'd0, r_irq_flag, 1'b0};
               c_REG_ADDRESS:   r_readdata <= 32'(r_address);
               c_REG_TYPE:      r_readdata <= {28'd0, r_type};
               c_REG_SAMPLES:   r_readdata <= 32'(r_samples);
               c_REG_WORDS:     r_readdata <= 32'(r_words);
               default:         r_readdata <= '0;
            endcase
         end
      end
   end

   assign bus.slave_readdata     = r_readdata;
   assign bus.slave_irq          = r_irq_flag && r_irq_enable;
   assign bus.master_address     = r_cur_addr;
   assign bus.master_read        = w_master_read;
   assign bus.dout_valid         = !w_fifo_empty;
   assign bus.dout_data          = w_fifo_empty ? 32'd0 : w_head[31:0];
   assign bus.dout_startofpacket = !w_fifo_empty && w_head[33];
   assign bus.dout_endofpacket   = !w_fifo_empty && w_head[32];
endmodule
`default_nettype wire

// File: tb/tb_vfr_packet_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vfr_packet_reader
//  Purpose  : Directed self-checking bench for vfr_packet_reader with an
//             in-order memory responder and an output stream monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vfr_packet_reader;
   logic clock;
   logic reset;

   vfr_packet_reader_if #(.ADDR_WIDTH(32)) bus ();

   vfr_packet_reader #(.FIFO_DEPTH(16), .ADDR_WIDTH(32), .WORDS_WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { int due; logic [31:0] data; } resp_t;

   int          checks = 0;
   int          failures = 0;
   resp_t       resp_q[$];
   logic [31:0] issued_q[$];
   logic [33:0] rx_q[$];
   int          ncyc = 0;
   int          lat = 2;
   int          stall_idx = -1;
   int          stall_left = 0;
   int          stall_ok = 0;
   int          stall_break = 0;
   int          issue_limit = 1000000;
   int          read_seen = 0;
   logic        irq_at_eop = 1'bx;
   logic        irq_after_eop = 1'bx;
   bit          irq_pend = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // memory word content: 0xA0 at 0x1000, incrementing per word
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA0 + ((a - 32'h1000) >> 2);
   endfunction

   // memory responder and stream monitor, evaluated between clock edges
   initial begin
      bus.master_waitrequest   = 1'b0;
      bus.master_readdatavalid = 1'b0;
      bus.master_readdata      = '0;
      forever begin
         resp_t r;
         @(negedge clock);
         ncyc++;
         if (resp_q.size() > 0 && resp_q[0].due <= ncyc) begin
            bus.master_readdatavalid = 1'b1;
            bus.master_readdata      = resp_q[0].data;
            void'(resp_q.pop_front());
         end else begin
            bus.master_readdatavalid = 1'b0;
            bus.master_readdata      = '0;
         end
         if (bus.master_read) begin
            read_seen++;
            if (issued_q.size() >= issue_limit) begin
               bus.master_waitrequest = 1'b1;
            end else if (issued_q.size() == stall_idx && stall_left > 0) begin
               bus.master_waitrequest = 1'b1;
               stall_left--;
               if (bus.master_address == 32'h1004) stall_ok++;
            end else begin
               bus.master_waitrequest = 1'b0;
               issued_q.push_back(bus.master_address);
               r.due  = ncyc + lat;
               r.data = mem_word(bus.master_address);
               resp_q.push_back(r);
            end
         end else begin
            if (issued_q.size() == stall_idx && stall_left > 0 && stall_left < 5) stall_break++;
            bus.master_waitrequest = 1'b0;
         end
         if (irq_pend) begin
            irq_after_eop = bus.slave_irq;
            irq_pend      = 0;
         end
         if (bus.dout_valid && bus.dout_ready) begin
            rx_q.push_back({bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data});
            if (bus.dout_endofpacket) begin
               irq_at_eop = bus.slave_irq;
               irq_pend   = 1;
            end
         end
      end
   end

   task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
      @(posedge clock); #1;
      bus.slave_address   = a;
      bus.slave_writedata = d;
      bus.slave_write     = 1'b1;
      @(posedge clock); #1;
      bus.slave_write     = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
      @(posedge clock); #1;
      bus.slave_address = a;
      bus.slave_read    = 1'b1;
      @(posedge clock); #1;
      bus.slave_read    = 1'b0;
      d = bus.slave_readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic clear_logs();
      issued_q.delete();
      rx_q.delete();
      read_seen   = 0;
      stall_ok    = 0;
      stall_break = 0;
   endtask

   task automatic wait_rx(input int n, input string name);
      int k = 0;
      while (rx_q.size() < n && k < 2000) begin
         @(negedge clock);
         k++;
      end
      checks++;
      if (rx_q.size() < n) begin
         failures++;
         $display("FAIL %s: timeout with %0d words received, required %0d", name, rx_q.size(), n);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      checks++;
      if ({bus.slave_readdata, bus.slave_irq, bus.master_read, bus.master_address, bus.dout_valid,
           bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rd=%h irq=%b mr=%b ma=%h v=%b data=%h", bus.slave_readdata,
                  bus.slave_irq, bus.master_read, bus.master_address, bus.dout_valid, bus.dout_data);
      end
      for (int a = 0; a < 7; a++) begin
         reg_read(3'(a), d);
         checks++;
         if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_reg%0d: got %h, required 00000000", a, d);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] d;
      logic [33:0] e;
      clear_logs();
      bus.dout_ready = 1'b1;
      reg_write(3, 32'h1000);
      reg_write(4, 32'h0);
      reg_write(5, 32'd12);
      reg_write(6, 32'd4);
      reg_write(0, 32'h3);
      wait_rx(5, "basic_len");
      idle(5);
      for (int i = 0; i < 5; i++) begin
         e = (i == 0) ? {2'b10, 32'h0} : {1'b0, (i == 4), 32'hA0 + 32'(i - 1)};
         checks++;
         if (i >= rx_q.size() || rx_q[i] !== e) begin
            failures++;
            $display("FAIL basic_word%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 34'h0, e);
         end
      end
      checks++;
      if (issued_q.size() != 4) begin
         failures++;
         $display("FAIL basic_nreads: got %0d, required 4", issued_q.size());
      end
      for (int i = 0; i < 4 && i < issued_q.size(); i++) begin
         checks++;
         if (issued_q[i] !== 32'h1000 + 32'(4 * i)) begin
            failures++;
            $display("FAIL basic_addr%0d: got %h, required %h", i, issued_q[i], 32'h1000 + 32'(4 * i));
         end
      end
      checks++;
      if (irq_at_eop !== 1'b0 || irq_after_eop !== 1'b1) begin
         failures++;
         $display("FAIL basic_irq_timing: got at_eop=%b after=%b, required 0 and 1", irq_at_eop, irq_after_eop);
      end
      reg_read(1, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL basic_status: got %h, required 00000000", d); end
      reg_read(7, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL basic_addr7: got %h, required 00000000", d); end
      reg_read(5, d);
      checks++;
      if (d !== 32'd12) begin failures++; $display("FAIL basic_samples: got %h, required 0000000c", d); end
      reg_write(2, 32'h2);
      checks++;
      if (bus.slave_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_clear: got %b, required 0", bus.slave_irq); end
   endtask

   task automatic test_zero_words();
      logic [31:0] d;
      clear_logs();
      reg_write(6, 32'd0);
      reg_write(4, 32'hF);
      reg_write(0, 32'h3);
      wait_rx(1, "zero_len");
      idle(5);
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== {2'b11, 32'hF}) begin
         failures++;
         $display("FAIL zero_word: got %0d words first=%h, required 1 word %h", rx_q.size(),
                  (rx_q.size() > 0) ? rx_q[0] : 34'h0, {2'b11, 32'hF});
      end
      checks++;
      if (read_seen != 0) begin failures++; $display("FAIL zero_no_read: got %0d read cycles, required 0", read_seen); end
      reg_read(2, d);
      checks++;
      if (d !== 32'h2) begin failures++; $display("FAIL zero_irq_flag: got %h, required 00000002", d); end
      reg_write(2, 32'h2);
   endtask

   task automatic test_backpressure();
      logic [33:0] e;
      clear_logs();
      bus.dout_ready = 1'b0;
      reg_write(4, 32'h5);
      reg_write(6, 32'd40);
      reg_write(0, 32'h3);
      idle(200);
      checks++;
      if (issued_q.size() != 15 || rx_q.size() != 0) begin
         failures++;
         $display("FAIL bp_stall: got %0d reads %0d words, required 15 reads 0 words", issued_q.size(), rx_q.size());
      end
      bus.dout_ready = 1'b1;
      wait_rx(41, "bp_len");
      idle(5);
      for (int i = 0; i < 41; i++) begin
         e = (i == 0) ? {2'b10, 32'h5} : {1'b0, (i == 40), 32'hA0 + 32'(i - 1)};
         checks++;
         if (i >= rx_q.size() || rx_q[i] !== e) begin
            failures++;
            $display("FAIL bp_word%0d: got %h, required %h", i, (i < rx_q.size()) ? rx_q[i] : 34'h0, e);
         end
      end
      checks++;
      if (issued_q.size() != 40 || issued_q[issued_q.size() - 1] !== 32'h109C) begin
         failures++;
         $display("FAIL bp_reads: got %0d reads, required 40 ending at 0000109c", issued_q.size());
      end
      reg_write(2, 32'h2);
   endtask

   task automatic test_waitrequest();
      clear_logs();
      stall_idx  = 1;
      stall_left = 5;
      reg_write(4, 32'h0);
      reg_write(6, 32'd4);
      reg_write(0, 32'h3);
      wait_rx(5, "wr_len");
      idle(5);
      checks++;
      if (stall_ok != 5 || stall_break != 0) begin
         failures++;
         $display("FAIL wr_hold: got %0d held cycles at 1004, %0d drops, required 5 and 0", stall_ok, stall_break);
      end
      checks++;
      if (issued_q.size() != 4 || issued_q[1] !== 32'h1004 || issued_q[2] !== 32'h1008) begin
         failures++;
         $display("FAIL wr_reads: got %0d reads, required 4 sequential from 00001000", issued_q.size());
      end
      checks++;
      if (rx_q.size() != 5 || rx_q[2] !== {2'b00, 32'hA1} || rx_q[4] !== {2'b01, 32'hA3}) begin
         failures++;
         $display("FAIL wr_stream: got %0d words, required 5 with A1 at 2 and A3 eop at 4", rx_q.size());
      end
      stall_idx = -1;
      reg_write(2, 32'h2);
   endtask

   task automatic test_go_while_running();
      logic [31:0] d;
      clear_logs();
      bus.dout_ready = 1'b0;
      reg_write(6, 32'd6);
      reg_write(0, 32'h1);
      idle(3);
      reg_write(6, 32'd2);
      reg_write(0, 32'h1);
      reg_read(6, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL gwr_words_rb: got %h, required 00000002", d); end
      reg_read(1, d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL gwr_running: got %h, required 00000001", d); end
      bus.dout_ready = 1'b1;
      wait_rx(7, "gwr_len");
      idle(20);
      checks++;
      if (rx_q.size() != 7 || rx_q[6] !== {2'b01, 32'hA5}) begin
         failures++;
         $display("FAIL gwr_length: got %0d words, required 7 ending in A5 eop", rx_q.size());
      end
      reg_read(2, d);
      checks++;
      if (d !== 32'h2 || bus.slave_irq !== 1'b0) begin
         failures++;
         $display("FAIL gwr_irq_masked: got flag reg %h irq %b, required 00000002 and 0", d, bus.slave_irq);
      end
      reg_read(0, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL gwr_control: got %h, required 00000000", d); end
      reg_write(2, 32'h2);
   endtask

   task automatic test_reset_mid_packet();
      int k = 0;
      clear_logs();
      bus.dout_ready = 1'b1;
      lat         = 20;
      issue_limit = 3;
      reg_write(3, 32'h1000);
      reg_write(4, 32'h0);
      reg_write(6, 32'd8);
      reg_write(0, 32'h3);
      while (issued_q.size() < 3 && k < 200) begin
         @(negedge clock);
         k++;
      end
      checks++;
      if (issued_q.size() != 3) begin
         failures++;
         $display("FAIL rst_setup: got %0d reads, required 3", issued_q.size());
      end
      rx_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      checks++;
      if ({bus.slave_readdata, bus.slave_irq, bus.master_read, bus.master_address, bus.dout_valid,
           bus.dout_data, bus.dout_startofpacket, bus.dout_endofpacket} !== '0) begin
         failures++;
         $display("FAIL rst_outputs: got mr=%b ma=%h v=%b data=%h irq=%b", bus.master_read,
                  bus.master_address, bus.dout_valid, bus.dout_data, bus.slave_irq);
      end
      read_seen   = 0;
      issue_limit = 1000000;
      idle(40);
      checks++;
      if (rx_q.size() != 0 || read_seen != 0 || resp_q.size() != 0) begin
         failures++;
         $display("FAIL rst_discard: got %0d words %0d read cycles %0d pending, required 0 0 0",
                  rx_q.size(), read_seen, resp_q.size());
      end
      lat = 2;
      clear_logs();
      reg_write(3, 32'h1000);
      reg_write(4, 32'h3);
      reg_write(6, 32'd3);
      reg_write(0, 32'h3);
      wait_rx(4, "rst_next_len");
      idle(5);
      checks++;
      if (rx_q.size() != 4 || rx_q[0] !== {2'b10, 32'h3} || rx_q[1] !== {2'b00, 32'hA0} ||
          rx_q[2] !== {2'b00, 32'hA1} || rx_q[3] !== {2'b01, 32'hA2}) begin
         failures++;
         $display("FAIL rst_next_packet: got %0d words, required 3/A0/A1/A2 with sop and eop", rx_q.size());
      end
   endtask

   initial begin
      reset                = 1'b0;
      bus.slave_address    = '0;
      bus.slave_write      = 1'b0;
      bus.slave_writedata  = '0;
      bus.slave_read       = 1'b0;
      bus.dout_ready       = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      reset = 1'b1;
      idle(2);
      test_reset();
      test_basic();
      test_zero_words();
      test_backpressure();
      test_waitrequest();
      test_go_while_running();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
